multicycle_controller: RTL and testbench

- Parametrised multi-cycle control unit for the core: a FETCH/DECODE/EXEC/MEM/WB state machine.
- Handshakes with instruction and data memory via req/ack.
- Latches the instruction fields, drives ALU/operand-select decode and emits one-cycle write strobes for PC, register file and link register.
- Adds wait-timeout error trapping and a retired-instruction counter.

---
 rtl/multicycle_controller.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// req/ack memory handshakes, combinational field decode, one-cycle
// write strobes in WB, wait-timeout error trap and a retired counter.
module multicycle_controller #(
    parameter int OP_W     = 6,
    parameter int FN_W     = 6,
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  opecode,
    input  logic [FN_W-1:0]  funct,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [5:0]       alu_func,
    output logic             reorim,
    output logic [1:0]       cp_type,
    output logic             write_reg,
    output logic             write_pc,
    output logic             write_lr,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    // Wait counter only has to reach WAIT_MAX-1.
    localparam int WC_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_MAX - 1);

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_JREG  = OP_W'(6'b111111);
    localparam logic [FN_W-1:0] FN_JR    = FN_W'(6'b001000);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_ERR
    } state_t;

    state_t          state;
    logic [OP_W-1:0] op_q;
    logic [FN_W-1:0] fn_q;
    logic [WC_W-1:0] wait_cnt;

    logic is_wr;
    logic is_mem;
    logic is_store;
    logic is_link;

    // Field decode from the latched instruction; also yields WB/MEM class bits.
    always_comb begin
        alu_func = '0;
        reorim   = 1'b0;
        cp_type  = 2'b00;
        is_wr    = 1'b0;
        is_mem   = 1'b0;
        is_store = 1'b0;
        is_link  = 1'b0;
        case (op_q)
            OP_RTYPE: begin
                alu_func = 6'(fn_q);
                if (fn_q == FN_JR) cp_type = 2'b01;
                else               is_wr   = 1'b1;
            end
            OP_ADDI: begin
                alu_func = 6'b100000;
                reorim   = 1'b1;
                is_wr    = 1'b1;
            end
            OP_ANDI: begin
                alu_func = 6'b100100;
                reorim   = 1'b1;
                is_wr    = 1'b1;
            end
            OP_ORI: begin
                alu_func = 6'b100101;
                reorim   = 1'b1;
                is_wr    = 1'b1;
            end
            OP_SLTI: begin
                alu_func = 6'b101010;
                reorim   = 1'b1;
                is_wr    = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                alu_func = 6'b100010;
                reorim   = 1'b1;
                cp_type  = 2'b11;
            end
            OP_LW: begin
                alu_func = 6'b100000;
                reorim   = 1'b1;
                is_wr    = 1'b1;
                is_mem   = 1'b1;
            end
            OP_SW: begin
                alu_func = 6'b100000;
                reorim   = 1'b1;
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OP_J:    cp_type = 2'b10;
            OP_JAL: begin
                cp_type = 2'b10;
                is_link = 1'b1;
            end
            OP_JREG: cp_type = 2'b01;
            default: ;
        endcase
    end

    // Sequencer; outputs are registered against the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            op_q      <= '0;
            fn_q      <= '0;
            wait_cnt  <= '0;
            retired   <= '0;
            err       <= 1'b0;
            imem_req  <= 1'b1;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            write_reg <= 1'b0;
            write_pc  <= 1'b0;
            write_lr  <= 1'b0;
        end else begin
            write_reg <= 1'b0;
            write_pc  <= 1'b0;
            write_lr  <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        op_q     <= opecode;
                        fn_q     <= funct;
                        wait_cnt <= '0;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        imem_req <= 1'b0;
                        err      <= 1'b1;
                        state    <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    if (is_mem) begin
                        wait_cnt <= '0;
                        dmem_req <= 1'b1;
                        dmem_we  <= is_store;
                        state    <= S_MEM;
                    end else begin
                        write_pc  <= 1'b1;
                        write_reg <= is_wr;
                        write_lr  <= is_link;
                        state     <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req  <= 1'b0;
                        dmem_we   <= 1'b0;
                        write_pc  <= 1'b1;
                        write_reg <= is_wr;
                        write_lr  <= is_link;
                        state     <= S_WB;
                    end else if (wait_cnt == WAIT_LAST) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        err      <= 1'b1;
                        state    <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WB: begin
                    retired  <= retired + 1'b1;
                    wait_cnt <= '0;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_ERR: ;
                default: begin
                    imem_req <= 1'b0;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    err      <= 1'b1;
                    state    <= S_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed + randomized bench for multicycle_controller. The reference is an
// instruction-level timeline: FETCH for (ack delay + 1) cycles, DECODE, EXEC,
// optional MEM for (ack delay + 1) cycles, WB; any wait beyond WAIT_MAX traps.
module tb_multicycle_controller;

    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       opecode;
    logic [5:0]       funct;
    logic             imem_ack;
    logic             dmem_ack;
    logic             imem_req;
    logic             dmem_req;
    logic             dmem_we;
    logic [5:0]       alu_func;
    logic             reorim;
    logic [1:0]       cp_type;
    logic             write_reg;
    logic             write_pc;
    logic             write_lr;
    logic             err;
    logic [CNT_W-1:0] retired;

    multicycle_controller #(
        .OP_W(6),
        .FN_W(6),
        .WAIT_MAX(WAIT_MAX),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .opecode(opecode),
        .funct(funct),
        .imem_ack(imem_ack),
        .dmem_ack(dmem_ack),
        .imem_req(imem_req),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .alu_func(alu_func),
        .reorim(reorim),
        .cp_type(cp_type),
        .write_reg(write_reg),
        .write_pc(write_pc),
        .write_lr(write_lr),
        .err(err),
        .retired(retired)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int retired_model = 0;

    typedef struct packed {
        logic [5:0] alu;
        logic       imm;
        logic [1:0] cp;
        logic       wreg;
        logic       wlr;
        logic       mem;
        logic       store;
    } dec_t;

    // Instruction semantics table.
    function automatic dec_t ref_decode(input logic [5:0] op, input logic [5:0] fn);
        dec_t d;
        d = '0;
        if (op == 6'b000000) begin
            d.alu  = fn;
            d.cp   = (fn == 6'b001000) ? 2'b01 : 2'b00;
            d.wreg = (fn != 6'b001000);
        end
        else if (op == 6'b001000) begin d.alu = 6'b100000; d.imm = 1; d.wreg = 1; end
        else if (op == 6'b001100) begin d.alu = 6'b100100; d.imm = 1; d.wreg = 1; end
        else if (op == 6'b001101) begin d.alu = 6'b100101; d.imm = 1; d.wreg = 1; end
        else if (op == 6'b001010) begin d.alu = 6'b101010; d.imm = 1; d.wreg = 1; end
        else if (op == 6'b000100 || op == 6'b000101) begin d.alu = 6'b100010; d.imm = 1; d.cp = 2'b11; end
        else if (op == 6'b100011) begin d.alu = 6'b100000; d.imm = 1; d.wreg = 1; d.mem = 1; end
        else if (op == 6'b101011) begin d.alu = 6'b100000; d.imm = 1; d.mem = 1; d.store = 1; end
        else if (op == 6'b000010) begin d.cp = 2'b10; end
        else if (op == 6'b000011) begin d.cp = 2'b10; d.wlr = 1; end
        else if (op == 6'b111111) begin d.cp = 2'b01; end
        return d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_cycle(input string ph, input logic ireq, input logic dreq,
                                input logic dwe, input logic wreg, input logic wpc,
                                input logic wlr, input logic e);
        check({ph, ".imem_req"},  32'(imem_req),  32'(ireq));
        check({ph, ".dmem_req"},  32'(dmem_req),  32'(dreq));
        check({ph, ".dmem_we"},   32'(dmem_we),   32'(dwe));
        check({ph, ".write_reg"}, 32'(write_reg), 32'(wreg));
        check({ph, ".write_pc"},  32'(write_pc),  32'(wpc));
        check({ph, ".write_lr"},  32'(write_lr),  32'(wlr));
        check({ph, ".err"},       32'(err),       32'(e));
        check({ph, ".retired"},   32'(retired),   32'(retired_model % (1 << CNT_W)));
    endtask

    task automatic check_dec(input string ph, input dec_t d);
        check({ph, ".alu_func"}, 32'(alu_func), 32'(d.alu));
        check({ph, ".reorim"},   32'(reorim),   32'(d.imm));
        check({ph, ".cp_type"},  32'(cp_type),  32'(d.cp));
    endtask

    task automatic noise();
        imem_ack = 1'($urandom_range(0, 1));
        dmem_ack = 1'($urandom_range(0, 1));
        opecode  = 6'($urandom);
        funct    = 6'($urandom);
    endtask

    task automatic err_phase();
        for (int k = 0; k < 4; k++) begin
            expect_cycle("ERR", 0, 0, 0, 0, 0, 0, 1);
            noise();
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        noise();
        @(negedge clk);
        rst = 1'b0;
        retired_model = 0;
        expect_cycle("reset", 1, 0, 0, 0, 0, 0, 0);
    endtask

    // Runs one instruction from its first FETCH cycle; entered and left at a negedge.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int di, input int dd, output bit trapped);
        dec_t d;
        d = ref_decode(op, fn);
        trapped = 0;
        for (int k = 0; k <= WAIT_MAX; k++) begin
            expect_cycle("FETCH", 1, 0, 0, 0, 0, 0, 0);
            noise();
            if (k == di) begin
                imem_ack = 1'b1;
                opecode  = op;
                funct    = fn;
            end else begin
                imem_ack = 1'b0;
            end
            @(negedge clk);
            if (k == di) break;
            if (k == WAIT_MAX - 1) begin
                trapped = 1;
                err_phase();
                return;
            end
        end
        expect_cycle("DECODE", 0, 0, 0, 0, 0, 0, 0);
        check_dec("DECODE", d);
        noise();
        @(negedge clk);
        expect_cycle("EXEC", 0, 0, 0, 0, 0, 0, 0);
        check_dec("EXEC", d);
        noise();
        @(negedge clk);
        if (d.mem) begin
            for (int k = 0; k <= WAIT_MAX; k++) begin
                expect_cycle("MEM", 0, 1, d.store, 0, 0, 0, 0);
                check_dec("MEM", d);
                noise();
                dmem_ack = (k == dd);
                @(negedge clk);
                if (k == dd) break;
                if (k == WAIT_MAX - 1) begin
                    trapped = 1;
                    err_phase();
                    return;
                end
            end
        end
        expect_cycle("WB", 0, 0, 0, d.wreg, 1, d.wlr, 0);
        check_dec("WB", d);
        noise();
        @(negedge clk);
        retired_model++;
    endtask

    logic [5:0] op_tab [12] = '{6'b000000, 6'b001000, 6'b001100, 6'b001101,
                                6'b001010, 6'b000100, 6'b000101, 6'b100011,
                                6'b101011, 6'b000010, 6'b000011, 6'b111111};

    initial begin
        bit         tr;
        int         idx;
        logic [5:0] op;
        logic [5:0] fn;

        rst = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        opecode = '0;
        funct = '0;
        @(negedge clk);
        rst = 1'b0;
        retired_model = 0;
        expect_cycle("reset", 1, 0, 0, 0, 0, 0, 0);
        check("reset.alu_func", 32'(alu_func), 32'd0);
        check("reset.cp_type", 32'(cp_type), 32'd0);

        // addi with immediate ack, then retired count of one
        run_instr(6'b001000, 6'h15, 0, 0, tr);
        check("addi.retired", 32'(retired), 32'd1);

        // lw with data ack in the 4th MEM cycle (also ack-beats-timeout case)
        run_instr(6'b100011, 6'h00, 0, 3, tr);
        check("lw.trapped", 32'(tr), 32'd0);

        // sw, jal, jr
        run_instr(6'b101011, 6'h3f, 1, 0, tr);
        run_instr(6'b000011, 6'h00, 0, 0, tr);
        run_instr(6'b000000, 6'b001000, 2, 0, tr);
        run_instr(6'b111111, 6'h2a, 0, 0, tr);

        // randomized instruction stream with occasional timeouts
        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 13);
            if (idx < 12) op = op_tab[idx];
            else op = 6'($urandom);
            fn = 6'($urandom);
            if (idx == 0 && $urandom_range(0, 3) == 0) fn = 6'b001000;
            run_instr(op, fn, $urandom_range(0, 4), $urandom_range(0, 4), tr);
            if (tr) do_reset();
        end

        // fetch timeout: no imem_ack for WAIT_MAX cycles
        do_reset();
        run_instr(6'b001000, 6'h00, 100, 0, tr);
        check("fetch_to.trapped", 32'(tr), 32'd1);
        do_reset();

        // data timeout
        run_instr(6'b101011, 6'h00, 0, 100, tr);
        check("mem_to.trapped", 32'(tr), 32'd1);
        do_reset();

        // reset during MEM of lw abandons it without strobes
        run_instr(6'b001101, 6'h00, 0, 0, tr);
        noise();
        imem_ack = 1'b1;
        opecode  = 6'b100011;
        @(negedge clk);
        noise();
        @(negedge clk);
        noise();
        dmem_ack = 1'b0;
        @(negedge clk);
        expect_cycle("pre_rst_MEM", 0, 1, 0, 0, 0, 0, 0);
        rst = 1'b1;
        dmem_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        retired_model = 0;
        expect_cycle("post_rst", 1, 0, 0, 0, 0, 0, 0);

        // counter wrap: nine NOPs with a 3-bit counter
        for (int n = 0; n < 9; n++) run_instr(6'b110000, 6'($urandom), 0, 0, tr);
        check("wrap.retired", 32'(retired), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
